// File: rtl/if_id_fetch_stage.sv
// ----------------------------------------------------------------------------
// Module : if_id_fetch_stage
// Purpose: Instruction-fetch stage and IF/ID pipeline register for the
//          5-stage MIPS pipeline. Holds the PC and drives the instruction
//          memory address. Picks either PC+4 or the branch target as the next
//          PC. Captures the fetched instruction and its PC+4 for decode.
//          PCWrite and IFIDWrite come from the hazard detection unit.
//
// Parameters:
//   RESET_PC   PC value loaded on reset
//   NOP_INSTR  encoding placed in IF/ID on reset/flush (sll $0,$0,0)
//   CNT_W      width of the stall counter (only with STALL_PERF_CNT_EN)
//
// Ports:
//   Clk           in   rising-edge clock
//   Rst_n         in   asynchronous active-low reset
//   PCWrite       in   1 = PC may update, 0 = hold PC (hazard stall)
//   IFIDWrite     in   1 = IF/ID may load, 0 = hold IF/ID (hazard stall)
//   Flush         in   1 = squash IF/ID on next edge (beats IFIDWrite)
//   PCSrc         in   1 = next PC is BranchTarget, 0 = PC+4
//   BranchTarget  in   redirect address from ID (low two bits ignored)
//   InstrIn       in   instruction memory data for address PCOut
//   PCOut         out  current PC / instruction memory address
//   IFIDInstr     out  registered instruction to ID
//   IFIDPCPlus4   out  registered PC+4 of IFIDInstr
//   IFIDValid     out  1 = real instruction, 0 = bubble
//   StallCount    out  stall-cycle counter, saturating (STALL_PERF_CNT_EN)
//   StallClr      in   synchronous clear of StallCount (STALL_PERF_CNT_EN)
//
// Configuration macro: STALL_PERF_CNT_EN adds the StallCount/StallClr
// performance counter. The default build leaves this macro undefined and has
// no counter.
// ----------------------------------------------------------------------------
module if_id_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             PCWrite,
  input  logic             IFIDWrite,
  input  logic             Flush,
  input  logic             PCSrc,
  input  logic [31:0]      BranchTarget,
  input  logic [31:0]      InstrIn,
  output logic [31:0]      PCOut,
  output logic [31:0]      IFIDInstr,
  output logic [31:0]      IFIDPCPlus4,
`ifdef STALL_PERF_CNT_EN
  output logic             IFIDValid,
  output logic [CNT_W-1:0] StallCount,
  input  logic             StallClr
`else
  output logic             IFIDValid
`endif
);

  logic [31:0] pcReg;
  logic [31:0] pcPlus4;
  logic [31:0] pcTarget;

  // Sequential address wraps at 2^32 because the carry out is dropped.
  // The redirect target is forced to word alignment by masking its low bits.
  assign pcPlus4  = pcReg + 32'd4;
  assign pcTarget = BranchTarget & ~32'd3;
  assign PCOut    = pcReg;

  // Program counter update. A stall holds the PC and ignores PCSrc, because
  // the hazard unit never resolves a branch during a stall.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pcReg <= RESET_PC;
    end else if (PCWrite) begin
      pcReg <= PCSrc ? pcTarget : pcPlus4;
    end
  end

  // IF/ID slot. Flush beats IFIDWrite, so a stall and a flush in the same
  // cycle still squash the slot to a bubble. With neither set, every field
  // holds, including IFIDValid.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      IFIDInstr   <= NOP_INSTR;
      IFIDPCPlus4 <= 32'd0;
      IFIDValid   <= 1'b0;
    end else if (Flush) begin
      IFIDInstr   <= NOP_INSTR;
      IFIDPCPlus4 <= 32'd0;
      IFIDValid   <= 1'b0;
    end else if (IFIDWrite) begin
      IFIDInstr   <= InstrIn;
      IFIDPCPlus4 <= pcPlus4;
      IFIDValid   <= 1'b1;
    end
  end

`ifdef STALL_PERF_CNT_EN
  logic stallCycle;

  assign stallCycle = !PCWrite && !IFIDWrite;

  // Stall counter. It counts full-pipeline-front stalls and stops at
  // all-ones instead of wrapping. StallClr wins over an increment.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      StallCount <= '0;
    end else if (StallClr) begin
      StallCount <= '0;
    end else if (stallCycle && (StallCount != {CNT_W{1'b1}})) begin
      StallCount <= StallCount + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// ----------------------------------------------------------------------------
// Testbench for if_id_fetch_stage.
// Instruction memory is modelled as InstrIn = PCOut | 1. Each scenario task
// first drives its inputs. It then pushes the predicted post-edge state into
// a queue, and a monitor pops that entry and compares it #1 after the edge.
// The tasks also check the fixed values from the reference sequences inline.
// ----------------------------------------------------------------------------
module tb_if_id_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        pcWrite = 1'b1;
  logic        ifidWrite = 1'b1;
  logic        flush = 1'b0;
  logic        pcSrc = 1'b0;
  logic [31:0] branchTarget = 32'd0;
  logic [31:0] instrIn;
  logic [31:0] pcOut;
  logic [31:0] ifidInstr;
  logic [31:0] ifidPcPlus4;
  logic        ifidValid;
  logic        stallClr = 1'b0;
  logic [15:0] stallCount;

  int assertCount = 0;
  int failCount = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pcp4;
    logic        valid;
    logic [15:0] cnt;
  } exp_t;

  exp_t sbQ[$];
  exp_t monExp;

  // Reference model state
  logic [31:0] mPc;
  logic [31:0] mInstr;
  logic [31:0] mPcp4;
  logic        mValid;
  logic [15:0] mCnt;

  assign instrIn = pcOut | 32'h1;

  if_id_fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(NOP),
    .CNT_W    (16)
  ) dut (
    .Clk         (clk),
    .Rst_n       (rstN),
    .PCWrite     (pcWrite),
    .IFIDWrite   (ifidWrite),
    .Flush       (flush),
    .PCSrc       (pcSrc),
    .BranchTarget(branchTarget),
    .InstrIn     (instrIn),
    .PCOut       (pcOut),
    .IFIDInstr   (ifidInstr),
    .IFIDPCPlus4 (ifidPcPlus4),
`ifdef STALL_PERF_CNT_EN
    .IFIDValid   (ifidValid),
    .StallCount  (stallCount),
    .StallClr    (stallClr)
`else
    .IFIDValid   (ifidValid)
`endif
  );

`ifndef STALL_PERF_CNT_EN
  assign stallCount = 16'd0;
`endif

  // 10-time-unit clock
  always #5 clk = ~clk;

  // Watchdog so the run always ends, even if the clock stalls
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scoreboard consumer: one predicted entry per clock edge
  always @(posedge clk) begin
    #1;
    if (sbQ.size() > 0) begin
      monExp = sbQ.pop_front();
      assertCount++;
      if (pcOut !== monExp.pc) begin
        failCount++;
        $display("[TB] FAIL sb_pc: got %h expected %h", pcOut, monExp.pc);
      end
      assertCount++;
      if (ifidInstr !== monExp.instr) begin
        failCount++;
        $display("[TB] FAIL sb_instr: got %h expected %h", ifidInstr, monExp.instr);
      end
      assertCount++;
      if (ifidPcPlus4 !== monExp.pcp4) begin
        failCount++;
        $display("[TB] FAIL sb_pcplus4: got %h expected %h", ifidPcPlus4, monExp.pcp4);
      end
      assertCount++;
      if (ifidValid !== monExp.valid) begin
        failCount++;
        $display("[TB] FAIL sb_valid: got %b expected %b", ifidValid, monExp.valid);
      end
`ifdef STALL_PERF_CNT_EN
      assertCount++;
      if (stallCount !== monExp.cnt) begin
        failCount++;
        $display("[TB] FAIL sb_stallcount: got %h expected %h", stallCount, monExp.cnt);
      end
`endif
    end
  end

  task automatic modelReset();
    mPc = 32'd0;
    mInstr = NOP;
    mPcp4 = 32'd0;
    mValid = 1'b0;
    mCnt = 16'd0;
  endtask

  // Predict the state after the next edge from the current inputs, then
  // push that prediction to the scoreboard.
  task automatic applyStimulus();
    logic [31:0] p4;
    p4 = mPc + 32'd4;
    if (flush) begin
      mInstr = NOP;
      mPcp4 = 32'd0;
      mValid = 1'b0;
    end else if (ifidWrite) begin
      mInstr = mPc | 32'h1;
      mPcp4 = p4;
      mValid = 1'b1;
    end
    if (stallClr) mCnt = 16'd0;
    else if (!pcWrite && !ifidWrite && mCnt != 16'hFFFF) mCnt = mCnt + 16'd1;
    if (pcWrite) mPc = pcSrc ? {branchTarget[31:2], 2'b00} : p4;
    sbQ.push_back('{pc: mPc, instr: mInstr, pcp4: mPcp4, valid: mValid, cnt: mCnt});
    @(posedge clk);
    #2;
  endtask

  task automatic setIn(input logic pw, input logic iw, input logic fl,
                       input logic ps, input logic [31:0] bt);
    pcWrite = pw;
    ifidWrite = iw;
    flush = fl;
    pcSrc = ps;
    branchTarget = bt;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    setIn(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    #12;
    assertCount++;
    if (pcOut !== 32'd0 || ifidInstr !== NOP || ifidPcPlus4 !== 32'd0 || ifidValid !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_state: got pc=%h instr=%h p4=%h v=%b expected 0/0/0/0",
               pcOut, ifidInstr, ifidPcPlus4, ifidValid);
    end
    @(posedge clk);
    #2;
    rstN = 1'b1;
    modelReset();
  endtask

  task automatic test_sequential();
    applyStimulus();
    assertCount++;
    if (pcOut !== 32'h4 || ifidInstr !== 32'h1 || ifidPcPlus4 !== 32'h4 || ifidValid !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL seq_first: got pc=%h instr=%h p4=%h v=%b expected 4/1/4/1",
               pcOut, ifidInstr, ifidPcPlus4, ifidValid);
    end
    applyStimulus();
    assertCount++;
    if (pcOut !== 32'h8 || ifidInstr !== 32'h5 || ifidPcPlus4 !== 32'h8) begin
      failCount++;
      $display("[TB] FAIL seq_second: got pc=%h instr=%h p4=%h expected 8/5/8",
               pcOut, ifidInstr, ifidPcPlus4);
    end
  endtask

  task automatic test_stall();
    setIn(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0400);
    applyStimulus();
    applyStimulus();
    assertCount++;
    if (pcOut !== 32'h8 || ifidInstr !== 32'h5 || ifidValid !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL stall_hold: got pc=%h instr=%h v=%b expected 8/5/1",
               pcOut, ifidInstr, ifidValid);
    end
`ifdef STALL_PERF_CNT_EN
    assertCount++;
    if (stallCount !== 16'd2) begin
      failCount++;
      $display("[TB] FAIL stall_count: got %0d expected 2", stallCount);
    end
`endif
    setIn(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    applyStimulus();
    assertCount++;
    if (pcOut !== 32'hC || ifidInstr !== 32'h9 || ifidPcPlus4 !== 32'hC) begin
      failCount++;
      $display("[TB] FAIL stall_resume: got pc=%h instr=%h p4=%h expected C/9/C",
               pcOut, ifidInstr, ifidPcPlus4);
    end
  endtask

  task automatic test_redirect();
    setIn(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0103);
    applyStimulus();
    assertCount++;
    if (pcOut !== 32'h100 || ifidInstr !== NOP || ifidValid !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL redirect: got pc=%h instr=%h v=%b expected 100/0/0",
               pcOut, ifidInstr, ifidValid);
    end
    setIn(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    applyStimulus();
    assertCount++;
    if (pcOut !== 32'h104 || ifidInstr !== 32'h101 || ifidPcPlus4 !== 32'h104 || ifidValid !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL redirect_fetch: got pc=%h instr=%h p4=%h v=%b expected 104/101/104/1",
               pcOut, ifidInstr, ifidPcPlus4, ifidValid);
    end
  endtask

  task automatic test_stall_flush();
    setIn(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0200);
    applyStimulus();
    assertCount++;
    if (pcOut !== 32'h104 || ifidInstr !== NOP || ifidPcPlus4 !== 32'd0 || ifidValid !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL stall_flush: got pc=%h instr=%h p4=%h v=%b expected 104/0/0/0",
               pcOut, ifidInstr, ifidPcPlus4, ifidValid);
    end
    setIn(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    applyStimulus();
  endtask

  task automatic test_wrap();
    setIn(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    applyStimulus();
    assertCount++;
    if (pcOut !== 32'hFFFF_FFFC) begin
      failCount++;
      $display("[TB] FAIL wrap_target: got %h expected FFFFFFFC", pcOut);
    end
    setIn(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    applyStimulus();
    assertCount++;
    if (pcOut !== 32'd0 || ifidInstr !== 32'hFFFF_FFFD || ifidPcPlus4 !== 32'd0) begin
      failCount++;
      $display("[TB] FAIL wrap_seq: got pc=%h instr=%h p4=%h expected 0/FFFFFFFD/0",
               pcOut, ifidInstr, ifidPcPlus4);
    end
  endtask

  task automatic test_async_reset();
    stallClr = 1'b1;
    setIn(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    applyStimulus();
    stallClr = 1'b0;
    setIn(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 5; i++) applyStimulus();
`ifdef STALL_PERF_CNT_EN
    assertCount++;
    if (stallCount !== 16'd5) begin
      failCount++;
      $display("[TB] FAIL stall_count5: got %0d expected 5", stallCount);
    end
`endif
    // Mid-cycle, away from any edge: reset must act immediately
    rstN = 1'b0;
    #1;
    assertCount++;
    if (pcOut !== 32'd0 || ifidInstr !== NOP || ifidPcPlus4 !== 32'd0 || ifidValid !== 1'b0
        || stallCount !== 16'd0) begin
      failCount++;
      $display("[TB] FAIL async_reset: got pc=%h instr=%h p4=%h v=%b cnt=%h expected all 0",
               pcOut, ifidInstr, ifidPcPlus4, ifidValid, stallCount);
    end
    @(posedge clk);
    #2;
    rstN = 1'b1;
    modelReset();
    setIn(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    applyStimulus();
  endtask

`ifdef STALL_PERF_CNT_EN
  task automatic test_saturation();
    setIn(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 65540; i++) applyStimulus();
    assertCount++;
    if (stallCount !== 16'hFFFF) begin
      failCount++;
      $display("[TB] FAIL saturate: got %h expected FFFF", stallCount);
    end
    stallClr = 1'b1;
    applyStimulus();
    stallClr = 1'b0;
    assertCount++;
    if (stallCount !== 16'd0) begin
      failCount++;
      $display("[TB] FAIL sat_clear: got %h expected 0", stallCount);
    end
    setIn(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    applyStimulus();
  endtask
`endif

  task automatic checkOutput();
    assertCount++;
    if (sbQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL sb_drain: got %0d pending entries expected 0", sbQ.size());
    end
  endtask

  initial begin
    modelReset();
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_stall_flush();
    test_wrap();
    test_async_reset();
`ifdef STALL_PERF_CNT_EN
    test_saturation();
`endif
    checkOutput();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
